// File: rtl/adc_conv_ctrl_if.sv
// Bundles the ADC-side and downstream valid/ready signals of the conversion controller.
// The master modport is the controller; the slave modport is the ADC plus the consumer.
interface adc_conv_ctrl_if #(
  parameter int NBITS = 12
) ();
  logic             adc_rst;
  logic             st_conv;
  logic             adc_done;
  logic [NBITS-1:0] adc_result;
  logic [NBITS-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output adc_rst, st_conv, data_out, data_valid,
    input  adc_done, adc_result, data_ready
  );

  modport slave (
    input  adc_rst, st_conv, data_out, data_valid,
    output adc_done, adc_result, data_ready
  );
endinterface

// File: rtl/adc_conv_ctrl.sv
// SAR ADC conversion initiator: resets the ADC, drives the sample window, waits for done,
// captures the result and presents it on valid/ready, with one-shot and periodic triggers.
module adc_conv_ctrl #(
  parameter int NBITS          = 12,
  parameter int SAMPLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int PERIOD_CYCLES  = 1000
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic start,
  input  logic cont_en,
  input  logic clr_flags,
  output logic busy,
  output logic timeout_err,
  output logic overrun,
  output logic trig_miss,
  adc_conv_ctrl_if.master bus
);
  localparam int SW = $clog2(SAMPLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(PERIOD_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CONV   = 3'd3,
    ST_CAPT   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [SW-1:0]    cnt_r, cnt_s;
  logic [TW-1:0]    tcnt_r, tcnt_s;
  logic [PW-1:0]    timer_r, timer_s;
  logic             st_conv_r, st_conv_s;
  logic             adc_rst_r, adc_rst_s;
  logic [NBITS-1:0] data_out_r, data_out_s;
  logic             data_valid_r, data_valid_s;
  logic             busy_r, busy_s;
  logic             timeout_r, timeout_s;
  logic             overrun_r, overrun_s;
  logic             trig_miss_r, trig_miss_s;
  logic             meta_r, s1_r, s2_r;
  logic             done_edge_s, timer_hit_s, trig_s;
  logic             capture_s, to_set_s, ov_set_s, miss_set_s;

  // adc_done is asynchronous: two flops for metastability, a third for the rising-edge detect
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
    end else begin
      meta_r <= bus.adc_done;
      s1_r   <= meta_r;
      s2_r   <= s1_r;
    end
  end

  assign done_edge_s = s1_r & ~s2_r;
  assign timer_hit_s = cont_en & (timer_r == PW'(PERIOD_CYCLES - 1));
  assign trig_s      = start | timer_hit_s;

  // Next-state, next-output and flag logic for the conversion sequencer
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    tcnt_s     = tcnt_r;
    st_conv_s  = st_conv_r;
    adc_rst_s  = adc_rst_r;
    data_out_s = data_out_r;
    capture_s  = 1'b0;
    to_set_s   = 1'b0;
    ov_set_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        adc_rst_s = 1'b1;
        if (cnt_r == SW'(1)) begin
          state_s   = ST_IDLE;
          adc_rst_s = 1'b0;
          cnt_s     = SW'(0);
        end else begin
          cnt_s = cnt_r + SW'(1);
        end
      end
      ST_IDLE: begin
        if (trig_s) begin
          st_conv_s = 1'b1;
          cnt_s     = SW'(SAMPLE_CYCLES - 1);
          state_s   = ST_SAMPLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (cnt_r == SW'(0)) begin
          st_conv_s = 1'b0;
          tcnt_s    = TW'(0);
          state_s   = ST_CONV;
        end else begin
          cnt_s = cnt_r - SW'(1);
        end
      end
      ST_CONV: begin
        tcnt_s = tcnt_r + TW'(1);
        if (done_edge_s) begin
          state_s = ST_CAPT;
        end else if (tcnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
          // abort and re-run the ADC reset sequence; no result is produced
          to_set_s  = 1'b1;
          adc_rst_s = 1'b1;
          cnt_s     = SW'(0);
          state_s   = ST_INIT;
        end else begin
          state_s = ST_CONV;
        end
      end
      ST_CAPT: begin
        capture_s  = 1'b1;
        data_out_s = bus.adc_result;
        state_s    = ST_IDLE;
      end
      default: begin
        state_s   = ST_INIT;
        st_conv_s = 1'b0;
        adc_rst_s = 1'b1;
        cnt_s     = SW'(0);
      end
    endcase

    // A capture coinciding with an accept keeps valid high with the new data
    if (capture_s) begin
      data_valid_s = 1'b1;
      ov_set_s     = data_valid_r & ~bus.data_ready;
    end else if (data_valid_r && bus.data_ready) begin
      data_valid_s = 1'b0;
    end else begin
      data_valid_s = data_valid_r;
    end

    if (!cont_en) begin
      timer_s = PW'(0);
    end else if (timer_hit_s) begin
      timer_s = PW'(0);
    end else begin
      timer_s = timer_r + PW'(1);
    end

    miss_set_s  = timer_hit_s & (state_r != ST_IDLE);
    timeout_s   = to_set_s   | (timeout_r   & ~clr_flags);
    overrun_s   = ov_set_s   | (overrun_r   & ~clr_flags);
    trig_miss_s = miss_set_s | (trig_miss_r & ~clr_flags);
    busy_s      = (state_s != ST_IDLE) | adc_rst_s;
  end

  // State, counters and all registered outputs
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_INIT;
      cnt_r        <= SW'(0);
      tcnt_r       <= TW'(0);
      timer_r      <= PW'(0);
      st_conv_r    <= 1'b0;
      adc_rst_r    <= 1'b1;
      data_out_r   <= NBITS'(0);
      data_valid_r <= 1'b0;
      busy_r       <= 1'b1;
      timeout_r    <= 1'b0;
      overrun_r    <= 1'b0;
      trig_miss_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      tcnt_r       <= tcnt_s;
      timer_r      <= timer_s;
      st_conv_r    <= st_conv_s;
      adc_rst_r    <= adc_rst_s;
      data_out_r   <= data_out_s;
      data_valid_r <= data_valid_s;
      busy_r       <= busy_s;
      timeout_r    <= timeout_s;
      overrun_r    <= overrun_s;
      trig_miss_r  <= trig_miss_s;
    end
  end

  assign bus.st_conv    = st_conv_r;
  assign bus.adc_rst    = adc_rst_r;
  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign busy           = busy_r;
  assign timeout_err    = timeout_r;
  assign overrun        = overrun_r;
  assign trig_miss      = trig_miss_r;
endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Directed bench for adc_conv_ctrl with a cycle-level SAR ADC model; period set to 40 cycles
// so both a fitting and an overlong conversion can be exercised on one instance.
module tb_adc_conv_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic start, cont_en, clr_flags;
  logic busy, timeout_err, overrun, trig_miss;

  int errors = 0;
  int checks = 0;

  int          adc_delay;
  logic        adc_never;
  logic [11:0] adc_next_result;
  logic [11:0] exp_val;
  int          adc_cd = 0;
  logic        adc_running = 1'b0;
  logic        st_prev = 1'b0;

  adc_conv_ctrl_if #(.NBITS(12)) bus ();

  adc_conv_ctrl #(
    .NBITS(12), .SAMPLE_CYCLES(8), .TIMEOUT_CYCLES(255), .PERIOD_CYCLES(40)
  ) dut (
    .clkin(clk), .rst_n(rst_n), .start(start), .cont_en(cont_en), .clr_flags(clr_flags),
    .busy(busy), .timeout_err(timeout_err), .overrun(overrun), .trig_miss(trig_miss),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ADC model: conversion starts at st_conv falling edge, done after adc_delay cycles
  always @(posedge clk) begin
    #2;
    if (bus.adc_rst || bus.st_conv) begin
      bus.adc_done   = 1'b0;
      bus.adc_result = adc_next_result;
      adc_running    = 1'b0;
    end else if (st_prev && !bus.st_conv) begin
      if (!adc_never) begin
        adc_running = 1'b1;
        adc_cd      = adc_delay;
      end
    end else if (adc_running) begin
      if (adc_cd <= 1) begin
        bus.adc_done   = 1'b1;
        bus.adc_result = adc_next_result;
        adc_running    = 1'b0;
      end else begin
        adc_cd = adc_cd - 1;
      end
    end
    st_prev = bus.st_conv;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.st_conv;
      1:       return bus.adc_rst;
      2:       return bus.data_valid;
      3:       return busy;
      4:       return timeout_err;
      5:       return bus.adc_done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int limit, input string tag,
                          output int n);
    n = 0;
    while (sig(sel) !== val && n < limit) begin
      step(1);
      n++;
    end
    check({tag, "_reached"}, 32'(sig(sel)), 32'(val));
  endtask

  task automatic run_conv(input logic [11:0] val);
    int n;
    adc_next_result = val;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_sig(3, 1'b0, 300, "conv_busy_low", n);
  endtask

  task automatic run_cont(input int total, input int stop_at, output int rises,
                          output int first_rise, output int min_iv, output int deliv);
    int   last;
    int   run;
    logic prev;
    rises = 0; first_rise = 0; min_iv = 100000; deliv = 0;
    last = 0; run = 0; prev = 1'b0;
    cont_en = 1'b1;
    for (int i = 1; i <= total; i++) begin
      step(1);
      if (bus.st_conv && !prev) begin
        rises++;
        if (rises == 1) first_rise = i;
        else if (i - last < min_iv) min_iv = i - last;
        last = i;
      end
      if (bus.st_conv) begin
        run++;
      end else if (prev) begin
        check("cont_st_conv_width", run, 8);
        run = 0;
      end
      if (bus.data_valid && bus.data_ready) begin
        check("cont_data", 32'(bus.data_out), 32'(exp_val));
        exp_val = exp_val + 12'd1;
        adc_next_result = exp_val;
        deliv++;
      end
      prev = bus.st_conv;
      if (i == stop_at) cont_en = 1'b0;
    end
  endtask

  initial begin
    int   n;
    int   rises, first_rise, min_iv, deliv;
    logic valid_seen;

    rst_n = 1'b0; start = 1'b0; cont_en = 1'b0; clr_flags = 1'b0;
    bus.data_ready = 1'b0;
    adc_delay = 14; adc_never = 1'b0; adc_next_result = 12'h000; exp_val = 12'h000;
    step(2);

    check("rst_st_conv", 32'(bus.st_conv), 32'd0);
    check("rst_adc_rst", 32'(bus.adc_rst), 32'd1);
    check("rst_data_valid", 32'(bus.data_valid), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'h000);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_flags", {29'd0, timeout_err, overrun, trig_miss}, 32'd0);

    rst_n = 1'b1;
    wait_sig(1, 1'b0, 10, "init_adc_rst", n);
    check("init_adc_rst_cycles", n, 2);
    check("idle_busy", 32'(busy), 32'd0);

    // one-shot conversion
    adc_next_result = 12'hA5C;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("st_conv_rise", 32'(bus.st_conv), 32'd1);
    wait_sig(0, 1'b0, 20, "st_conv_fall", n);
    check("st_conv_width", n, 8);
    wait_sig(5, 1'b1, 100, "adc_done_seen", n);
    wait_sig(2, 1'b1, 10, "valid_rise", n);
    check("done_to_valid", n, 4);
    check("data_a5c", 32'(bus.data_out), 32'hA5C);

    // accept, then overrun with ready low
    bus.data_ready = 1'b1;
    step(1);
    check("accept_clears_valid", 32'(bus.data_valid), 32'd0);
    bus.data_ready = 1'b0;
    run_conv(12'h123);
    check("data_123", 32'(bus.data_out), 32'h123);
    check("valid_123", 32'(bus.data_valid), 32'd1);
    check("no_overrun_yet", 32'(overrun), 32'd0);
    run_conv(12'h456);
    check("data_456", 32'(bus.data_out), 32'h456);
    check("overrun_set", 32'(overrun), 32'd1);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);
    check("data_456_kept", 32'(bus.data_out), 32'h456);
    bus.data_ready = 1'b1;
    step(1);
    check("accept_456", 32'(bus.data_valid), 32'd0);

    // timeout: ADC never answers
    adc_never = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_sig(0, 1'b0, 20, "to_st_conv_fall", n);
    n = 0;
    valid_seen = 1'b0;
    while (!timeout_err && n < 400) begin
      step(1);
      n++;
      valid_seen = valid_seen | bus.data_valid;
    end
    check("timeout_cycles", n, 255);
    check("timeout_adc_rst", 32'(bus.adc_rst), 32'd1);
    check("timeout_no_data", 32'(valid_seen), 32'd0);
    wait_sig(1, 1'b0, 10, "timeout_adc_rst_low", n);
    check("timeout_adc_rst_cycles", n, 2);
    adc_never = 1'b0;
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("timeout_cleared", 32'(timeout_err), 32'd0);
    run_conv(12'h777);
    check("data_777", 32'(bus.data_out), 32'h777);
    check("valid_777", 32'(bus.data_valid), 32'd1);
    step(2);

    // periodic triggering, conversion fits in the period
    exp_val = 12'h100;
    adc_next_result = 12'h100;
    run_cont(240, 170, rises, first_rise, min_iv, deliv);
    check("cont_rises", rises, 4);
    check("cont_first_rise", first_rise, 40);
    check("cont_period", min_iv, 40);
    check("cont_delivered", deliv, 4);
    check("cont_no_miss", 32'(trig_miss), 32'd0);

    // periodic triggering, conversion longer than the period
    adc_delay = 40;
    exp_val = 12'h200;
    adc_next_result = 12'h200;
    run_cont(240, 190, rises, first_rise, min_iv, deliv);
    check("slow_rises", rises, 2);
    check("slow_first_rise", first_rise, 40);
    check("slow_min_interval", min_iv, 80);
    check("slow_delivered", deliv, 2);
    check("slow_trig_miss", 32'(trig_miss), 32'd1);

    // reset in the middle of SAMPLE
    adc_delay = 14;
    bus.data_ready = 1'b0;
    run_conv(12'h321);
    check("pre_rst_valid", 32'(bus.data_valid), 32'd1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    check("mid_sample", 32'(bus.st_conv), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_sample_st_conv", 32'(bus.st_conv), 32'd0);
    check("rst_sample_valid", 32'(bus.data_valid), 32'd0);
    check("rst_sample_adc_rst", 32'(bus.adc_rst), 32'd1);
    check("rst_sample_flags", {29'd0, timeout_err, overrun, trig_miss}, 32'd0);
    step(1);
    rst_n = 1'b1;
    wait_sig(1, 1'b0, 10, "rst_sample_init", n);
    check("rst_sample_init_cycles", n, 2);

    // reset in the middle of CONV
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_sig(0, 1'b0, 20, "conv_entry", n);
    step(5);
    check("mid_conv_busy", 32'(busy), 32'd1);
    check("mid_conv_adc_rst", 32'(bus.adc_rst), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_conv_adc_rst", 32'(bus.adc_rst), 32'd1);
    check("rst_conv_valid", 32'(bus.data_valid), 32'd0);
    step(1);
    rst_n = 1'b1;
    wait_sig(1, 1'b0, 10, "rst_conv_init", n);
    check("rst_conv_init_cycles", n, 2);
    bus.data_ready = 1'b1;
    run_conv(12'h654);
    check("data_654", 32'(bus.data_out), 32'h654);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
